cong_don: RTL and testbench



---
 rtl/cong_don_pkg.sv | 18 +
 rtl/cong_don_acc_add.sv | 46 ++++
 rtl/cong_don.sv | 121 ++++++++++++
 tb/tb_cong_don.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cong_don_pkg.sv
// Shared types and default constants for the cong_don frame accumulator.
package cong_don_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } cd_state_e;

   localparam int unsigned CD_IN_W  = 9;
   localparam int unsigned CD_LEN   = 8;
   localparam int unsigned CD_ACC_W = 12;

   // Sample counter width; a one-sample frame still needs a 1-bit counter.
   function automatic int unsigned cd_cnt_w(input int unsigned len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

endpackage

// File: rtl/cong_don_acc_add.sv
// Ripple-carry accumulator adder built from fa cells.
// CONG_DON_SAT_EN selects a saturating result on carry out; otherwise the sum wraps.
module fa (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module acc_add #(
   parameter int unsigned W = 12
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_c_o,
   output logic         cout_c_o
);
   logic [W:0]   carry;
   logic [W-1:0] raw;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_bit
      fa u_fa (
         .a_i  (a_i[i]),
         .b_i  (b_i[i]),
         .ci_i (carry[i]),
         .s_o  (raw[i]),
         .co_o (carry[i+1])
      );
   end

   assign cout_c_o = carry[W];

`ifdef CONG_DON_SAT_EN
   // Clamp to all-ones; a clamped accumulator keeps re-clamping on any further nonzero add.
   assign sum_c_o = carry[W] ? {W{1'b1}} : raw;
`else
   assign sum_c_o = raw;
`endif

endmodule

// File: rtl/cong_don.sv
// Frame accumulator: sums LEN product-sum samples and holds the result on a handshake.
// Saturating accumulation is enabled by defining CONG_DON_SAT_EN.
module cong_don
   import cong_don_pkg::*;
#(
   parameter int unsigned IN_W  = CD_IN_W,
   parameter int unsigned LEN   = CD_LEN,
   parameter int unsigned ACC_W = CD_ACC_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf
);

   localparam int unsigned      CNT_W    = cd_cnt_w(LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

   cd_state_e        state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic             out_ovf_q, out_ovf_d;

   logic [ACC_W-1:0] in_ext;
   logic [ACC_W-1:0] sum;
   logic             carry;
   logic             accept;

   assign in_ext   = ACC_W'(in_data);
   assign in_ready = (state_q == ACC);
   assign accept   = in_valid & in_ready & ~flush;

   acc_add #(.W(ACC_W)) u_add (
      .a_i      (acc_q),
      .b_i      (in_ext),
      .sum_c_o  (sum),
      .cout_c_o (carry)
   );

   // Next-state: flush overrides any accept or result handshake in the same cycle.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;

      if (flush) begin
         state_d     = ACC;
         acc_d       = '0;
         cnt_d       = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ACC: begin
               if (accept) begin
                  if (cnt_q == CNT_LAST) begin
                     out_data_d  = sum;
                     out_ovf_d   = ovf_q | carry;
                     out_valid_d = 1'b1;
                     acc_d       = '0;
                     cnt_d       = '0;
                     ovf_d       = 1'b0;
                     state_d     = DONE;
                  end else begin
                     acc_d = sum;
                     ovf_d = ovf_q | carry;
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = ACC;
               end
            end
            default: begin
               state_d = ACC;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cong_don.sv
// Scoreboard bench for cong_don: four instances cover LEN=4, LEN=2, overflow and LEN=1.
module tb_cong_don;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [8:0] din = '0;
   logic       vld = 1'b0;
   logic       fl = 1'b0;
   logic       ordy = 1'b1;
   logic [1:0] sel = 2'd0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   logic [3:0] vld_v, fl_v, ordy_v, rdy;
   logic       rdy_sel;

   logic        a_ov, a_oo, b_ov, b_oo, c_ov, c_oo, d_ov, d_oo;
   logic [11:0] a_od, b_od, d_od;
   logic [9:0]  c_od;

   typedef struct {
      int d;
      int o;
      int c;
   } exp_t;

   exp_t sbq[4][$];
   bit   seen[4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         vld_v[k]  = vld && (sel == 2'(k));
         fl_v[k]   = fl && (sel == 2'(k));
         ordy_v[k] = (sel == 2'(k)) ? ordy : 1'b1;
      end
   end
   assign rdy_sel = rdy[sel];

   cong_don #(.IN_W(9), .LEN(4), .ACC_W(12)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(vld_v[0]), .in_ready(rdy[0]), .in_data(din),
      .flush(fl_v[0]), .out_valid(a_ov), .out_ready(ordy_v[0]), .out_data(a_od), .out_ovf(a_oo));
   cong_don #(.IN_W(9), .LEN(2), .ACC_W(12)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(vld_v[1]), .in_ready(rdy[1]), .in_data(din),
      .flush(fl_v[1]), .out_valid(b_ov), .out_ready(ordy_v[1]), .out_data(b_od), .out_ovf(b_oo));
   cong_don #(.IN_W(9), .LEN(3), .ACC_W(10)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(vld_v[2]), .in_ready(rdy[2]), .in_data(din),
      .flush(fl_v[2]), .out_valid(c_ov), .out_ready(ordy_v[2]), .out_data(c_od), .out_ovf(c_oo));
   cong_don #(.IN_W(9), .LEN(1), .ACC_W(12)) u_d (
      .clk(clk), .rst_n(rst_n), .in_valid(vld_v[3]), .in_ready(rdy[3]), .in_data(din),
      .flush(fl_v[3]), .out_valid(d_ov), .out_ready(ordy_v[3]), .out_data(d_od), .out_ovf(d_oo));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic expect_res(input int k, input int d, input int o, input int c);
      exp_t e;
      e.d = d;
      e.o = o;
      e.c = c;
      sbq[k].push_back(e);
   endtask

   // Monitor: first visible cycle checks latency; every held cycle checks value and in_ready.
   task automatic mon(input int k, input logic ov, input logic [11:0] od, input logic oo,
                      input logic ir, input logic ork);
      exp_t e;
      if (!ov) return;
      if (sbq[k].size() == 0) begin
         chk($sformatf("inst%0d unexpected_result", k), 1, 0);
         return;
      end
      e = sbq[k][0];
      if (!seen[k]) begin
         chk($sformatf("inst%0d latency_cycle", k), cyc, e.c);
         seen[k] = 1'b1;
      end
      chk($sformatf("inst%0d in_ready_while_valid", k), int'(ir), 0);
      chk($sformatf("inst%0d out_data", k), int'(od), e.d);
      chk($sformatf("inst%0d out_ovf", k), int'(oo), e.o);
      if (ork) begin
         void'(sbq[k].pop_front());
         seen[k] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      mon(0, a_ov, a_od, a_oo, rdy[0], ordy_v[0]);
      mon(1, b_ov, b_od, b_oo, rdy[1], ordy_v[1]);
      mon(2, c_ov, {2'b00, c_od}, c_oo, rdy[2], ordy_v[2]);
      mon(3, d_ov, d_od, d_oo, rdy[3], ordy_v[3]);
   end

   // Offer one sample to the selected instance; returns the cycle count just after acceptance.
   task automatic send(input int x, output int ac);
      int   n;
      logic ready;
      n   = 0;
      vld = 1'b1;
      din = 9'(x);
      forever begin
         @(negedge clk);
         ready = rdy_sel;
         @(posedge clk);
         #1;
         if (ready) break;
         n++;
         if (n > 50) begin
            chk("send_timeout", n, 0);
            break;
         end
      end
      ac  = cyc;
      vld = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int ac, r;
      int ovf_exp;
`ifdef CONG_DON_SAT_EN
      ovf_exp = 1023;
`else
      ovf_exp = 326;
`endif
      #1 rst_n = 1'b0;
      #2;
      chk("reset out_valid", int'(a_ov), 0);
      chk("reset out_data", int'(a_od), 0);
      chk("reset out_ovf", int'(a_oo), 0);
      chk("reset in_ready", int'(rdy[0]), 1);
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // Default frame, LEN=4
      sel = 2'd0;
      send(54, ac); send(174, ac); send(237, ac); send(73, ac);
      expect_res(0, 538, 0, ac);
      idle(3);

      // Backpressure, LEN=2, then resume the cycle after the handshake
      sel  = 2'd1;
      ordy = 1'b0;
      send(115, ac); send(94, ac);
      expect_res(1, 209, 0, ac);
      idle(5);
      r    = cyc;
      ordy = 1'b1;
      send(10, ac);
      chk("resume_accept_cycle", ac, r + 2);
      send(20, ac);
      expect_res(1, 30, 0, ac);
      idle(3);

      // Overflow, ACC_W=10, LEN=3, then a clean frame
      sel = 2'd2;
      send(450, ac); send(450, ac); send(450, ac);
      expect_res(2, ovf_exp, 1, ac);
      send(1, ac); send(2, ac); send(3, ac);
      expect_res(2, 6, 0, ac);
      idle(3);

      // Flush mid-frame drops the concurrent sample
      sel = 2'd0;
      send(54, ac); send(174, ac);
      vld = 1'b1;
      din = 9'd237;
      fl  = 1'b1;
      idle(1);
      fl  = 1'b0;
      vld = 1'b0;
      send(1, ac); send(2, ac); send(3, ac); send(4, ac);
      expect_res(0, 10, 0, ac);
      idle(3);

      // LEN=1: each sample is a frame
      sel = 2'd3;
      send(450, ac);
      expect_res(3, 450, 0, ac);
      send(0, ac);
      expect_res(3, 0, 0, ac);
      idle(3);

      // Reset while a result is held
      sel  = 2'd0;
      ordy = 1'b0;
      send(54, ac); send(174, ac); send(237, ac); send(73, ac);
      expect_res(0, 538, 0, ac);
      idle(3);
      sbq[0].delete();
      seen[0] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midhold_reset out_valid", int'(a_ov), 0);
      chk("midhold_reset out_data", int'(a_od), 0);
      chk("midhold_reset out_ovf", int'(a_oo), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      ordy = 1'b1;
      @(negedge clk);
      chk("midhold_reset in_ready", int'(rdy[0]), 1);
      idle(3);

      for (int k = 0; k < 4; k++)
         chk($sformatf("inst%0d pending_results", k), sbq[k].size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
